// File: rtl/mdom_trig_pkg.sv
// Shared constants and helpers for the multi-channel mDOM trigger.
package mdom_trig_pkg;

    localparam int PIPE_LAT = 2;

    localparam logic [1:0] TRIG_SRC_THRESH = 2'd0;
    localparam logic [1:0] TRIG_SRC_DISCR  = 2'd1;
    localparam logic [1:0] TRIG_SRC_SW     = 2'd2;
    localparam logic [1:0] TRIG_SRC_EXT    = 2'd3;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/mdom_chan_trig.sv
// One trigger channel: compare/edge detect, coincidence window, holdoff and
// the two-stage stream delay that keeps trig aligned with the output sample.
module mdom_chan_trig
    import mdom_trig_pkg::*;
#(
    parameter int P_ADC_WIDTH     = 12,
    parameter int P_DISCR_WIDTH   = 8,
    parameter int P_WIN_WIDTH     = 4,
    parameter int P_HOLDOFF_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [P_ADC_WIDTH-1:0]     adc_i,
    input  logic [P_DISCR_WIDTH-1:0]   discr_i,
    input  logic [P_ADC_WIDTH-1:0]     thr_i,
    input  logic                       gt_i,
    input  logic                       et_i,
    input  logic                       lt_i,
    input  logic                       thresh_en_i,
    input  logic                       discr_en_i,
    input  logic                       discr_pol_i,
    input  logic                       sw_cand_i,
    input  logic                       ext_cand_i,
    input  logic                       coinc_mode_i,
    input  logic                       coinc_fire_i,
    input  logic [P_WIN_WIDTH-1:0]     coinc_win_i,
    input  logic [P_HOLDOFF_WIDTH-1:0] holdoff_i,
    output logic                       member_o,
    output logic [P_ADC_WIDTH-1:0]     adc_o,
    output logic [P_DISCR_WIDTH-1:0]   discr_o,
    output logic                       trig_o,
    output logic [1:0]                 trig_src_o,
    output logic                       thresh_tot_o
);

    logic [P_ADC_WIDTH-1:0]     adc_s1_q, adc_s2_q;
    logic [P_DISCR_WIDTH-1:0]   discr_s1_q, discr_s2_q;
    logic                       v1_q, cond_prev_q, level_prev_q;
    logic [P_WIN_WIDTH-1:0]     win_cnt_q, win_cnt_d;
    logic [1:0]                 win_src_q, win_src_d;
    logic [P_HOLDOFF_WIDTH-1:0] ho_q, ho_d;
    logic                       trig_q, tot_q;
    logic [1:0]                 src_q;

    logic       cond, level, thr_cand, dis_cand, held, loc_cand, win_flag, fire_loc, fire;
    logic [1:0] loc_src, mem_src, src;

    // v1_q masks the reset value of stage 1 so it never looks like a sample.
    assign cond = v1_q & ((gt_i & (adc_s1_q > thr_i)) |
                          (et_i & (adc_s1_q == thr_i)) |
                          (lt_i & (adc_s1_q < thr_i)));
    assign level = v1_q & (discr_pol_i ? |discr_s1_q : ~&discr_s1_q);

    assign thr_cand = thresh_en_i & cond & ~cond_prev_q;
    assign dis_cand = discr_en_i & level & ~level_prev_q;
    assign held     = ho_q != '0;
    assign loc_cand = ~held & (thr_cand | dis_cand);
    assign loc_src  = dis_cand ? TRIG_SRC_DISCR : TRIG_SRC_THRESH;
    assign win_flag = win_cnt_q != '0;
    assign member_o = ~held & (loc_cand | win_flag);
    assign mem_src  = loc_cand ? loc_src : win_src_q;

    assign fire_loc = coinc_mode_i ? (coinc_fire_i & member_o) : loc_cand;
    assign fire     = ~held & (ext_cand_i | sw_cand_i | fire_loc);
    assign src      = ext_cand_i ? TRIG_SRC_EXT : (sw_cand_i ? TRIG_SRC_SW : mem_src);

    always_comb begin
        win_cnt_d = win_cnt_q;
        win_src_d = win_src_q;
        if (!coinc_mode_i || coinc_fire_i) begin
            win_cnt_d = '0;
        end else if (loc_cand) begin
            win_cnt_d = coinc_win_i;
            win_src_d = loc_src;
        end else if (win_flag) begin
            win_cnt_d = win_cnt_q - P_WIN_WIDTH'(1);
        end
        // The firing cycle itself counts as the first holdoff cycle.
        ho_d = ho_q;
        if (fire)
            ho_d = (holdoff_i == '0) ? '0 : holdoff_i - P_HOLDOFF_WIDTH'(1);
        else if (held)
            ho_d = ho_q - P_HOLDOFF_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_s1_q     <= '0;
            adc_s2_q     <= '0;
            discr_s1_q   <= '0;
            discr_s2_q   <= '0;
            v1_q         <= 1'b0;
            cond_prev_q  <= 1'b0;
            level_prev_q <= 1'b0;
            win_cnt_q    <= '0;
            win_src_q    <= '0;
            ho_q         <= '0;
            trig_q       <= 1'b0;
            src_q        <= '0;
            tot_q        <= 1'b0;
        end else begin
            adc_s1_q     <= adc_i;
            adc_s2_q     <= adc_s1_q;
            discr_s1_q   <= discr_i;
            discr_s2_q   <= discr_s1_q;
            v1_q         <= 1'b1;
            cond_prev_q  <= cond;
            level_prev_q <= level;
            win_cnt_q    <= win_cnt_d;
            win_src_q    <= win_src_d;
            ho_q         <= ho_d;
            trig_q       <= fire;
            src_q        <= fire ? src : 2'd0;
            tot_q        <= cond;
        end
    end

    assign adc_o        = adc_s2_q;
    assign discr_o      = discr_s2_q;
    assign trig_o       = trig_q;
    assign trig_src_o   = src_q;
    assign thresh_tot_o = tot_q;

endmodule

// File: rtl/mdom_trigger_multi.sv
// Multi-channel mDOM trigger: global sw/ext edge detection, coincidence
// decision across channels, and the per-channel trigger array.
module mdom_trigger_multi
    import mdom_trig_pkg::*;
#(
    parameter int P_N_CHAN        = 4,
    parameter int P_ADC_WIDTH     = 12,
    parameter int P_DISCR_WIDTH   = 8,
    parameter int P_WIN_WIDTH     = 4,
    parameter int P_HOLDOFF_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [P_N_CHAN*P_ADC_WIDTH-1:0]   adc_stream_in,
    input  logic [P_N_CHAN*P_DISCR_WIDTH-1:0] discr_stream_in,
    output logic [P_N_CHAN*P_ADC_WIDTH-1:0]   adc_stream_out,
    output logic [P_N_CHAN*P_DISCR_WIDTH-1:0] discr_stream_out,
    input  logic [P_N_CHAN*P_ADC_WIDTH-1:0]   thr,
    input  logic                              gt,
    input  logic                              et,
    input  logic                              lt,
    input  logic                              thresh_trig_en,
    input  logic                              discr_trig_en,
    input  logic                              ext_trig_en,
    input  logic                              discr_trig_pol,
    input  logic                              run,
    input  logic                              ext_run,
    input  logic                              coinc_en,
    input  logic [$clog2(P_N_CHAN+1)-1:0]     coinc_mult,
    input  logic [P_WIN_WIDTH-1:0]            coinc_win,
    input  logic [P_HOLDOFF_WIDTH-1:0]        holdoff,
    output logic [P_N_CHAN-1:0]               trig,
    output logic [2*P_N_CHAN-1:0]             trig_src,
    output logic [P_N_CHAN-1:0]               thresh_tot,
    output logic                              coinc_trig
);

    logic ext_meta_q, ext_sync_q, ext_s1_q, ext_prev_q;
    logic run_s1_q, run_prev_q, coinc_trig_q;
    logic sw_cand, ext_cand, coinc_mode, coinc_fire;
    logic [P_N_CHAN-1:0] member;
    logic [4:0] mult_ext, n_member;

    // ext_run: 2-flop synchroniser, then the same stage-1 slot as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_meta_q   <= 1'b0;
            ext_sync_q   <= 1'b0;
            ext_s1_q     <= 1'b0;
            ext_prev_q   <= 1'b0;
            run_s1_q     <= 1'b0;
            run_prev_q   <= 1'b0;
            coinc_trig_q <= 1'b0;
        end else begin
            ext_meta_q   <= ext_run;
            ext_sync_q   <= ext_meta_q;
            ext_s1_q     <= ext_sync_q;
            ext_prev_q   <= ext_s1_q;
            run_s1_q     <= run;
            run_prev_q   <= run_s1_q;
            coinc_trig_q <= coinc_fire;
        end
    end

    assign sw_cand    = run_s1_q & ~run_prev_q;
    assign ext_cand   = ext_trig_en & ext_s1_q & ~ext_prev_q;
    assign mult_ext   = 5'(coinc_mult);
    assign n_member   = popcount(16'(member));
    // A multiplicity of 0 or 1 degenerates to singles.
    assign coinc_mode = coinc_en & (mult_ext >= 5'd2);
    assign coinc_fire = coinc_mode & (n_member >= mult_ext);
    assign coinc_trig = coinc_trig_q;

    for (genvar c = 0; c < P_N_CHAN; c++) begin : g_chan
        mdom_chan_trig #(
            .P_ADC_WIDTH     (P_ADC_WIDTH),
            .P_DISCR_WIDTH   (P_DISCR_WIDTH),
            .P_WIN_WIDTH     (P_WIN_WIDTH),
            .P_HOLDOFF_WIDTH (P_HOLDOFF_WIDTH)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .adc_i        (adc_stream_in[c*P_ADC_WIDTH +: P_ADC_WIDTH]),
            .discr_i      (discr_stream_in[c*P_DISCR_WIDTH +: P_DISCR_WIDTH]),
            .thr_i        (thr[c*P_ADC_WIDTH +: P_ADC_WIDTH]),
            .gt_i         (gt),
            .et_i         (et),
            .lt_i         (lt),
            .thresh_en_i  (thresh_trig_en),
            .discr_en_i   (discr_trig_en),
            .discr_pol_i  (discr_trig_pol),
            .sw_cand_i    (sw_cand),
            .ext_cand_i   (ext_cand),
            .coinc_mode_i (coinc_mode),
            .coinc_fire_i (coinc_fire),
            .coinc_win_i  (coinc_win),
            .holdoff_i    (holdoff),
            .member_o     (member[c]),
            .adc_o        (adc_stream_out[c*P_ADC_WIDTH +: P_ADC_WIDTH]),
            .discr_o      (discr_stream_out[c*P_DISCR_WIDTH +: P_DISCR_WIDTH]),
            .trig_o       (trig[c]),
            .trig_src_o   (trig_src[2*c +: 2]),
            .thresh_tot_o (thresh_tot[c])
        );
    end

endmodule
